// File: rtl/core_inst_pkg.sv
// Shared definitions for the core instruction bus: field layout, idle word and
// pass-sequencer state encoding.
package core_inst_pkg;

  localparam int INST_W       = 34;

  localparam int ACC_POS      = 33;
  localparam int ACC_W        = 1;
  localparam int CEN_PMEM_POS = 32;
  localparam int CEN_PMEM_W   = 1;
  localparam int WEN_PMEM_POS = 31;
  localparam int WEN_PMEM_W   = 1;
  localparam int A_PMEM_POS   = 20;
  localparam int A_PMEM_W     = 11;
  localparam int CEN_XMEM_POS = 19;
  localparam int CEN_XMEM_W   = 1;
  localparam int WEN_XMEM_POS = 18;
  localparam int WEN_XMEM_W   = 1;
  localparam int A_XMEM_POS   = 7;
  localparam int A_XMEM_W     = 11;
  localparam int OFIFO_RD_POS = 6;
  localparam int OFIFO_RD_W   = 1;
  localparam int IFIFO_WR_POS = 5;
  localparam int IFIFO_WR_W   = 1;
  localparam int IFIFO_RD_POS = 4;
  localparam int IFIFO_RD_W   = 1;
  localparam int L0_RD_POS    = 3;
  localparam int L0_RD_W      = 1;
  localparam int L0_WR_POS    = 2;
  localparam int L0_WR_W      = 1;
  localparam int EXECUTE_POS  = 1;
  localparam int EXECUTE_W    = 1;
  localparam int LOAD_POS     = 0;
  localparam int LOAD_W       = 1;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic        acc;
    logic        cen_pmem;
    logic        wen_pmem;
    logic [10:0] a_pmem;
    logic        cen_xmem;
    logic        wen_xmem;
    logic [10:0] a_xmem;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        execute;
    logic        load;
  } inst_t;

  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_WLD   = 4'd1;
  localparam logic [3:0] S_KLOAD = 4'd2;
  localparam logic [3:0] S_GAP1  = 4'd3;
  localparam logic [3:0] S_ALD   = 4'd4;
  localparam logic [3:0] S_EXEC  = 4'd5;
  localparam logic [3:0] S_GAP2  = 4'd6;
  localparam logic [3:0] S_WAITQ = 4'd7;
  localparam logic [3:0] S_WB    = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  typedef enum logic [3:0] {
    ST_IDLE  = S_IDLE,
    ST_WLD   = S_WLD,
    ST_KLOAD = S_KLOAD,
    ST_GAP1  = S_GAP1,
    ST_ALD   = S_ALD,
    ST_EXEC  = S_EXEC,
    ST_GAP2  = S_GAP2,
    ST_WAITQ = S_WAITQ,
    ST_WB    = S_WB,
    ST_DONE  = S_DONE
  } state_e;

endpackage

// File: rtl/core_pass_ctrl.sv
// Sequencer for one kernel-position pass: weight load, kernel load, activation
// load, execute and OFIFO drain into PSUM memory, all via the registered inst bus.
module core_pass_ctrl
  import core_inst_pkg::*;
#(
  parameter int          COL     = 8,
  parameter int          LEN_NIJ = 64,
  parameter logic [10:0] W_BASE  = 11'h400,
  parameter logic [10:0] A_BASE  = 11'h000,
  parameter int          GAP_CYC = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [10:0]       pmem_base,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam int PH_A   = (2 * COL + 1 > LEN_NIJ + 2) ? 2 * COL + 1 : LEN_NIJ + 2;
  localparam int PH_MAX = (PH_A > GAP_CYC) ? PH_A : GAP_CYC;
  localparam int CNT_W  = $clog2(PH_MAX + 1);
  localparam int WD_W   = $clog2(LEN_NIJ + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WLD_LAST  = CNT_W'(COL);
  localparam logic [CNT_W-1:0] KLD_LAST  = CNT_W'(2 * COL);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] ALD_LAST  = CNT_W'(LEN_NIJ);
  localparam logic [CNT_W-1:0] EXE_LAST  = CNT_W'(LEN_NIJ + 1);
  localparam logic [CNT_W-1:0] W_READS   = CNT_W'(COL);
  localparam logic [CNT_W-1:0] A_READS   = CNT_W'(LEN_NIJ);
  localparam logic [WD_W-1:0]  WD_ZERO   = {WD_W{1'b0}};
  localparam logic [WD_W-1:0]  WD_ONE    = WD_W'(1);
  localparam logic [WD_W-1:0]  WB_WORDS  = WD_W'(LEN_NIJ);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WD_W-1:0]    r_word;
  logic               r_pend;
  logic [10:0]        r_base;
  logic [INST_W-1:0]  r_inst;
  logic               r_busy;
  logic               r_done;

  state_e             w_state_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [WD_W-1:0]    w_word_next;
  logic               w_pend_next;
  logic [10:0]        w_base_next;
  inst_t              w_inst;

  // Next-state and next-instruction decode for the current state cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CNT_ONE;
    w_word_next  = r_word;
    w_pend_next  = 1'b0;
    w_base_next  = r_base;
    w_inst       = IDLE_INST;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = CNT_ZERO;
        if (start) begin
          w_state_next = ST_WLD;
          w_base_next  = pmem_base;
          w_word_next  = WD_ZERO;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WLD: begin
        // L0 write trails the XMEM read by the one-cycle SRAM latency.
        if (r_cnt < W_READS) begin
          w_inst.cen_xmem = 1'b0;
          w_inst.a_xmem   = W_BASE + 11'(r_cnt);
        end else begin
          w_inst.cen_xmem = 1'b1;
        end
        w_inst.l0_wr = (r_cnt != CNT_ZERO);
        if (r_cnt == WLD_LAST) begin
          w_state_next = ST_KLOAD;
          w_cnt_next   = CNT_ZERO;
        end else begin
          w_state_next = ST_WLD;
        end
      end
      ST_KLOAD: begin
        w_inst.l0_rd = 1'b1;
        w_inst.load  = (r_cnt != CNT_ZERO);
        if (r_cnt == KLD_LAST) begin
          w_state_next = ST_GAP1;
          w_cnt_next   = CNT_ZERO;
        end else begin
          w_state_next = ST_KLOAD;
        end
      end
      ST_GAP1: begin
        if (r_cnt == GAP_LAST) begin
          w_state_next = ST_ALD;
          w_cnt_next   = CNT_ZERO;
        end else begin
          w_state_next = ST_GAP1;
        end
      end
      ST_ALD: begin
        if (r_cnt < A_READS) begin
          w_inst.cen_xmem = 1'b0;
          w_inst.a_xmem   = A_BASE + 11'(r_cnt);
        end else begin
          w_inst.cen_xmem = 1'b1;
        end
        w_inst.l0_wr = (r_cnt != CNT_ZERO);
        if (r_cnt == ALD_LAST) begin
          w_state_next = ST_EXEC;
          w_cnt_next   = CNT_ZERO;
        end else begin
          w_state_next = ST_ALD;
        end
      end
      ST_EXEC: begin
        w_inst.l0_rd   = 1'b1;
        w_inst.execute = (r_cnt != CNT_ZERO);
        if (r_cnt == EXE_LAST) begin
          w_state_next = ST_GAP2;
          w_cnt_next   = CNT_ZERO;
        end else begin
          w_state_next = ST_EXEC;
        end
      end
      ST_GAP2: begin
        if (r_cnt == GAP_LAST) begin
          w_state_next = ST_WAITQ;
          w_cnt_next   = CNT_ZERO;
        end else begin
          w_state_next = ST_GAP2;
        end
      end
      ST_WAITQ: begin
        w_cnt_next = CNT_ZERO;
        if (ofifo_valid) begin
          w_state_next = ST_WB;
          w_word_next  = WD_ZERO;
        end else begin
          w_state_next = ST_WAITQ;
        end
      end
      ST_WB: begin
        // r_word counts completed reads; the pending write lands at the slot
        // of the read issued last cycle, so a stall never skips an address.
        w_cnt_next = CNT_ZERO;
        if (r_pend) begin
          w_inst.cen_pmem = 1'b0;
          w_inst.wen_pmem = 1'b0;
          w_inst.a_pmem   = r_base + 11'(r_word) - 11'd1;
        end else begin
          w_inst.cen_pmem = 1'b1;
        end
        if (ofifo_valid && (r_word < WB_WORDS)) begin
          w_inst.ofifo_rd = 1'b1;
          w_pend_next     = 1'b1;
          w_word_next     = r_word + WD_ONE;
        end else begin
          w_pend_next     = 1'b0;
        end
        if (r_pend && (r_word == WB_WORDS)) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_WB;
        end
      end
      ST_DONE: begin
        w_cnt_next   = CNT_ZERO;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_cnt_next   = CNT_ZERO;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any pass in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_word  <= WD_ZERO;
      r_pend  <= 1'b0;
      r_base  <= 11'h000;
      r_inst  <= IDLE_INST;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_word  <= w_word_next;
      r_pend  <= w_pend_next;
      r_base  <= w_base_next;
      r_inst  <= w_inst;
      r_busy  <= (w_state_next != ST_IDLE);
      r_done  <= (r_state == ST_DONE);
    end
  end

  assign inst = r_inst;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_core_pass_ctrl.sv
// Randomised self-checking bench for core_pass_ctrl: a phase-table model predicts
// the bus every cycle, and per-pass totals are pinned to hand-computed numbers.
module tb_core_pass_ctrl;

  localparam int COL   = 8;
  localparam int LEN   = 64;
  localparam int GAP   = 10;
  localparam int FIXED = (COL + 1) + (2 * COL + 1) + GAP + (LEN + 1) + (LEN + 2) + GAP;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [10:0] pmem_base;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_err    = 0;

  // model state
  int          m_mode = 0;
  int          m_p, m_reads, m_wr;
  bit          m_pend;
  logic [10:0] m_base;

  // observed running totals
  int          o_xrd = 0, o_l0wr = 0, o_load = 0, o_exec = 0, o_rd = 0, o_wr = 0, o_done = 0;
  logic [10:0] o_last_wr = 11'h000;

  always #5 clk = ~clk;

  core_pass_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .pmem_base   (pmem_base),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Bus word for cycle p of the fixed-length part of a pass (before WAITQ).
  function automatic logic [33:0] fixed_inst(input int p);
    logic [33:0] v;
    int t;
    v = IDLE_W;
    t = p;
    if (t < COL + 1) begin
      if (t < COL) begin v[19] = 1'b0; v[17:7] = 11'h400 + 11'(t); end
      if (t >= 1) v[2] = 1'b1;
      return v;
    end
    t -= COL + 1;
    if (t < 2 * COL + 1) begin
      v[3] = 1'b1;
      if (t >= 1) v[0] = 1'b1;
      return v;
    end
    t -= 2 * COL + 1;
    if (t < GAP) return v;
    t -= GAP;
    if (t < LEN + 1) begin
      if (t < LEN) begin v[19] = 1'b0; v[17:7] = 11'h000 + 11'(t); end
      if (t >= 1) v[2] = 1'b1;
      return v;
    end
    t -= LEN + 1;
    if (t < LEN + 2) begin
      v[3] = 1'b1;
      if (t >= 1) v[1] = 1'b1;
      return v;
    end
    return v;
  endfunction

  // One clock: advance the model on the inputs seen at this edge, compare, tally.
  task automatic tick();
    logic [33:0] ei;
    logic eb, ed;
    @(posedge clk);
    ei = IDLE_W; eb = 1'b0; ed = 1'b0;
    if (!reset_n) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: begin
          eb = start;
          if (start) begin m_mode = 1; m_p = 0; m_base = pmem_base; end
        end
        1: begin
          ei = fixed_inst(m_p); eb = 1'b1; m_p++;
          if (m_p == FIXED) m_mode = 2;
        end
        2: begin
          eb = 1'b1;
          if (ofifo_valid) begin m_mode = 3; m_reads = 0; m_wr = 0; m_pend = 1'b0; end
        end
        3: begin
          eb = 1'b1;
          if (m_pend) begin
            ei[32] = 1'b0; ei[31] = 1'b0; ei[30:20] = m_base + 11'(m_wr); m_wr++;
          end
          if (m_reads < LEN && ofifo_valid) begin ei[6] = 1'b1; m_reads++; m_pend = 1'b1; end
          else m_pend = 1'b0;
          if (m_wr == LEN) m_mode = 4;
        end
        default: begin ed = 1'b1; m_mode = 0; end
      endcase
    end
    #1;
    chk("inst", 64'(inst), 64'(ei));
    chk("busy_done", 64'({busy, done}), 64'({eb, ed}));
    if (!inst[19]) o_xrd++;
    if (inst[2]) o_l0wr++;
    if (inst[0]) o_load++;
    if (inst[1]) o_exec++;
    if (inst[6]) o_rd++;
    if (!inst[32]) begin o_wr++; o_last_wr = inst[30:20]; end
    if (done) o_done++;
    @(negedge clk);
  endtask

  // mode 0: ofifo_valid held high; 1: 5-cycle drop after 20 reads; 2: random.
  task automatic run_pass(input logic [10:0] base, input int mode, input bit busy_starts,
                          input int exp_last);
    int s_xrd, s_l0wr, s_load, s_exec, s_rd, s_wr, s_done;
    int stall_left;
    bit stalled, seen;
    s_xrd = o_xrd; s_l0wr = o_l0wr; s_load = o_load; s_exec = o_exec;
    s_rd = o_rd; s_wr = o_wr; s_done = o_done;
    stall_left = 0; stalled = 1'b0; seen = 1'b0;
    pmem_base = base;
    ofifo_valid = (mode != 2) ? 1'b1 : 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      case (mode)
        0: ofifo_valid = 1'b1;
        1: begin
          if (!stalled && (o_rd - s_rd) == 20) begin stalled = 1'b1; stall_left = 5; end
          ofifo_valid = (stall_left > 0) ? 1'b0 : 1'b1;
          if (stall_left > 0) stall_left--;
        end
        default: ofifo_valid = ($urandom_range(0, 3) != 0);
      endcase
      start = (busy_starts && (cyc % 40) == 20) ? 1'b1 : 1'b0;
      tick();
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
    chk("done_seen", 64'(seen), 64'(1));
    repeat (6) tick();
    chk("xmem_reads", 64'(o_xrd - s_xrd), 64'(72));
    chk("l0_writes", 64'(o_l0wr - s_l0wr), 64'(72));
    chk("load_cycles", 64'(o_load - s_load), 64'(16));
    chk("exec_cycles", 64'(o_exec - s_exec), 64'(65));
    chk("ofifo_reads", 64'(o_rd - s_rd), 64'(64));
    chk("pmem_writes", 64'(o_wr - s_wr), 64'(64));
    chk("done_pulses", 64'(o_done - s_done), 64'(1));
    chk("idle_busy", 64'(busy), 64'(0));
    if (exp_last >= 0) chk("last_wr_addr", 64'(o_last_wr), 64'(exp_last));
    if (mode == 1) chk("stall_hit", 64'(stalled), 64'(1));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; pmem_base = 11'h000; ofifo_valid = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("reset_inst", 64'(inst), 64'(34'h1_800C_0000));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    reset_n = 1'b1;
    tick();

    run_pass(11'h001, 0, 1'b0, 64);
    run_pass(11'($urandom_range(0, 2047)), 1, 1'b0, -1);
    run_pass(11'h7F0, 0, 1'b1, 11'h02F);

    // abort in the middle of EXEC with an asynchronous reset
    pmem_base = 11'h123; ofifo_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (120) tick();
    chk("mid_exec", 64'(inst[1]), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("async_inst", 64'(inst), 64'(34'h1_800C_0000));
    chk("async_busy", 64'(busy), 64'(0));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    run_pass(11'($urandom_range(0, 2047)), 2, 1'b0, -1);

    for (int i = 0; i < 2; i++) begin
      run_pass(11'($urandom_range(0, 2047)), 2, 1'b1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
